// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: command sequencer for a bidirectional shift register.
// Accepts LOAD / ROTL / ROTR / CLEAR commands over valid/ready.
// It drives the register's serial controls for N cycles (RUN).
// It then captures the register's parallel output in a settle cycle (CAP).
// Optional feature macro: SHIFT_SEQ_ROT_REDUCE_EN. When defined, rotates are
// shortened to at most WIDTH/2 shifts, flipping direction when that is shorter.
module shift_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_cnt,
    output logic             sr_d,
    output logic             sr_en,
    output logic             sr_dir,
    output logic             sr_circular,
    input  logic [WIDTH-1:0] sr_q,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res_data
);

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_ROTL  = 2'b01;
    localparam logic [1:0] OP_ROTR  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    localparam logic [CNT_W-1:0] LP_WIDTH = CNT_W'(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_CAP  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    // Remaining shifts after the one currently being driven
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_next;
    // LOAD payload still to be serialised, next bit in the MSB
    logic [WIDTH-1:0]   r_data;
    logic [WIDTH-1:0]   w_data_next;

    logic               r_sr_d;
    logic               r_sr_en;
    logic               r_sr_dir;
    logic               r_sr_circ;
    logic               r_done;
    logic [WIDTH-1:0]   r_res;
    logic               w_sr_d_next;
    logic               w_sr_en_next;
    logic               w_sr_dir_next;
    logic               w_sr_circ_next;
    logic               w_done_next;
    logic [WIDTH-1:0]   w_res_next;

    // Rotate plan: shift count and whether the commanded direction is flipped
    logic [CNT_W-1:0]   w_rot_n;
    logic               w_rot_flip;

    // Shift plan for the command currently offered
    logic [CNT_W-1:0]   w_acc_n;
    logic               w_acc_dir;
    logic               w_acc_circ;

    logic               w_accept;

    assign cmd_ready   = (r_state == ST_IDLE);
    assign busy        = ~cmd_ready;
    assign w_accept    = cmd_valid & cmd_ready;

    assign sr_d        = r_sr_d;
    assign sr_en       = r_sr_en;
    assign sr_dir      = r_sr_dir;
    assign sr_circular = r_sr_circ;
    assign done        = r_done;
    assign res_data    = r_res;

`ifdef SHIFT_SEQ_ROT_REDUCE_EN
    localparam logic [CNT_W-1:0] LP_HALF = CNT_W'(WIDTH / 2);

    logic [CNT_W-1:0]   w_rot_e;

    // Fold the count into one revolution, then take the shorter way round
    always_comb begin
        w_rot_e    = (cmd_cnt >= LP_WIDTH) ? (cmd_cnt - LP_WIDTH) : cmd_cnt;
        w_rot_flip = (w_rot_e > LP_HALF);
        w_rot_n    = w_rot_flip ? (LP_WIDTH - w_rot_e) : w_rot_e;
    end
`else
    // Rotate exactly as commanded
    always_comb begin
        w_rot_flip = 1'b0;
        w_rot_n    = cmd_cnt;
    end
`endif

    // Per-opcode shift count, direction and rotate mode
    always_comb begin
        w_acc_n    = LP_WIDTH;
        w_acc_dir  = 1'b0;
        w_acc_circ = 1'b0;
        case (cmd_op)
            OP_ROTL: begin
                w_acc_n    = w_rot_n;
                w_acc_dir  = w_rot_flip;
                w_acc_circ = 1'b1;
            end
            OP_ROTR: begin
                w_acc_n    = w_rot_n;
                w_acc_dir  = ~w_rot_flip;
                w_acc_circ = 1'b1;
            end
            default: begin
                w_acc_n    = LP_WIDTH;
                w_acc_dir  = 1'b0;
                w_acc_circ = 1'b0;
            end
        endcase
    end

    // Next-state and next-output logic; outputs are registered from these
    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_data_next    = r_data;
        w_sr_d_next    = 1'b0;
        w_sr_en_next   = 1'b0;
        w_sr_dir_next  = r_sr_dir;
        w_sr_circ_next = r_sr_circ;
        w_done_next    = 1'b0;
        w_res_next     = r_res;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_acc_n != '0) begin
                        w_state_next   = ST_RUN;
                        w_cnt_next     = w_acc_n - 1'b1;
                        w_sr_en_next   = 1'b1;
                        w_sr_dir_next  = w_acc_dir;
                        w_sr_circ_next = w_acc_circ;
                        // Only LOAD feeds payload bits; others shift in zeros
                        if (cmd_op == OP_LOAD) begin
                            w_sr_d_next = cmd_data[WIDTH-1];
                            w_data_next = {cmd_data[WIDTH-2:0], 1'b0};
                        end else begin
                            w_sr_d_next = 1'b0;
                            w_data_next = '0;
                        end
                    end else begin
                        w_state_next = ST_CAP;
                    end
                end
            end
            ST_RUN: begin
                if (r_cnt == '0) begin
                    w_state_next = ST_CAP;
                end else begin
                    w_cnt_next   = r_cnt - 1'b1;
                    w_sr_en_next = 1'b1;
                    w_sr_d_next  = r_data[WIDTH-1];
                    w_data_next  = {r_data[WIDTH-2:0], 1'b0};
                end
            end
            ST_CAP: begin
                w_state_next = ST_IDLE;
                w_res_next   = sr_q;
                w_done_next  = 1'b1;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Datapath and registered outputs; reset aborts any command in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_data    <= '0;
            r_sr_d    <= 1'b0;
            r_sr_en   <= 1'b0;
            r_sr_dir  <= 1'b0;
            r_sr_circ <= 1'b0;
            r_done    <= 1'b0;
            r_res     <= '0;
        end else begin
            r_cnt     <= w_cnt_next;
            r_data    <= w_data_next;
            r_sr_d    <= w_sr_d_next;
            r_sr_en   <= w_sr_en_next;
            r_sr_dir  <= w_sr_dir_next;
            r_sr_circ <= w_sr_circ_next;
            r_done    <= w_done_next;
            r_res     <= w_res_next;
        end
    end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Testbench for shift_seq_ctrl (WIDTH=8) with a behavioural shift register
// attached and a value-level reference model of the command results.
module tb_shift_seq_ctrl;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_ROTL  = 2'b01;
    localparam logic [1:0] OP_ROTR  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;
    logic [3:0] cmd_cnt;
    logic       sr_d;
    logic       sr_en;
    logic       sr_dir;
    logic       sr_circular;
    logic [7:0] sr_q = 8'h00;
    logic       busy;
    logic       done;
    logic [7:0] res_data;

    int errors = 0;
    int checks = 0;

    // Reference: value the register should hold after the last command
    logic [7:0] m_q = 8'h00;

    shift_seq_ctrl #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_data    (cmd_data),
        .cmd_cnt     (cmd_cnt),
        .sr_d        (sr_d),
        .sr_en       (sr_en),
        .sr_dir      (sr_dir),
        .sr_circular (sr_circular),
        .sr_q        (sr_q),
        .busy        (busy),
        .done        (done),
        .res_data    (res_data)
    );

    always #5 clk = ~clk;

    // Controlled shift register (not reset by the controller's reset)
    always @(posedge clk) begin
        if (sr_en === 1'b1) begin
            if (sr_dir)
                sr_q <= {(sr_circular ? sr_q[0] : sr_d), sr_q[7:1]};
            else
                sr_q <= {sr_q[6:0], (sr_circular ? sr_q[7] : sr_d)};
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int s);
        logic [15:0] w;
        w = {v, v} >> (8 - s);
        return w[7:0];
    endfunction

    function automatic logic [7:0] rotr8(input logic [7:0] v, input int s);
        logic [15:0] w;
        w = {v, v} >> s;
        return w[7:0];
    endfunction

    // Called at the negedge of the first cycle after acceptance; returns at
    // the negedge of the done cycle (or after the cycle budget expires).
    task automatic watch_cmd(input logic [1:0] op, input logic [7:0] data,
                             input logic [3:0] cnt, input string name);
        int         n;
        int         e;
        logic       exp_dir;
        logic       exp_circ;
        logic [7:0] exp_res;
        int         en_cnt;
        int         first_en;
        int         last_en;
        int         done_t;
        bit         dir_ok;
        bit         circ_ok;
        bit         d_ok;
        bit         ready_ok;
        logic [7:0] got_d;
        en_cnt = 0; first_en = -1; last_en = -1; done_t = -1;
        dir_ok = 1; circ_ok = 1; d_ok = 1; ready_ok = 1; got_d = 8'h00;
        e = int'(cnt) % 8;
        n = 8; exp_dir = 1'b0; exp_circ = 1'b0; exp_res = 8'h00;
        case (op)
            OP_LOAD:  begin n = 8; exp_res = data; end
            OP_CLEAR: begin n = 8; exp_res = 8'h00; end
            OP_ROTL:  begin n = int'(cnt); exp_circ = 1'b1; exp_dir = 1'b0; exp_res = rotl8(m_q, e); end
            default:  begin n = int'(cnt); exp_circ = 1'b1; exp_dir = 1'b1; exp_res = rotr8(m_q, e); end
        endcase
`ifdef SHIFT_SEQ_ROT_REDUCE_EN
        if (op == OP_ROTL || op == OP_ROTR) begin
            if (e > 4) begin
                n = 8 - e;
                exp_dir = ~exp_dir;
            end else begin
                n = e;
            end
        end
`endif
        for (int t = 0; t < 40; t++) begin
            if (sr_en === 1'b1) begin
                if (first_en < 0) first_en = t;
                last_en = t;
                en_cnt++;
                got_d = {got_d[6:0], sr_d};
                if (sr_dir !== exp_dir) dir_ok = 0;
                if (sr_circular !== exp_circ) circ_ok = 0;
                if (op != OP_LOAD && sr_d !== 1'b0) d_ok = 0;
            end
            if (done === 1'b1) begin
                done_t = t;
                break;
            end
            if (cmd_ready !== 1'b0 || busy !== 1'b1) ready_ok = 0;
            @(negedge clk);
        end
        checks++;
        if (done_t != n + 1) begin
            errors++;
            $display("FAIL %s latency: done at cycle %0d after accept, required %0d", name, done_t + 1, n + 2);
        end
        checks++;
        if (en_cnt != n || (n > 0 && (first_en != 0 || last_en != n - 1))) begin
            errors++;
            $display("FAIL %s sr_en: %0d cycles (first %0d last %0d), required %0d from cycle 0", name, en_cnt, first_en, last_en, n);
        end
        if (n > 0) begin
            checks++;
            if (!dir_ok) begin
                errors++;
                $display("FAIL %s sr_dir: wrong during shifts, required %0b", name, exp_dir);
            end
            checks++;
            if (!circ_ok) begin
                errors++;
                $display("FAIL %s sr_circular: wrong during shifts, required %0b", name, exp_circ);
            end
            checks++;
            if (op == OP_LOAD) begin
                if (got_d !== data) begin
                    errors++;
                    $display("FAIL %s sr_d: serial bits %h, required %h", name, got_d, data);
                end
            end else if (!d_ok) begin
                errors++;
                $display("FAIL %s sr_d: nonzero serial data, required 0", name);
            end
        end
        checks++;
        if (!ready_ok) begin
            errors++;
            $display("FAIL %s busy: cmd_ready/busy wrong while command in progress", name);
        end
        if (done_t >= 0) begin
            checks++;
            if (res_data !== exp_res) begin
                errors++;
                $display("FAIL %s res_data: got %h, required %h", name, res_data, exp_res);
            end
            checks++;
            if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL %s ready_at_done: cmd_ready=%b busy=%b, required 1/0", name, cmd_ready, busy);
            end
        end
        $display("cmd %s op=%0d data=%h cnt=%0d shifts=%0d done_cycle=%0d res=%h exp=%h",
                 name, op, data, cnt, en_cnt, done_t + 1, res_data, exp_res);
        m_q = exp_res;
    endtask

    // Offer a command, wait for acceptance, then watch it to completion
    task automatic do_cmd(input logic [1:0] op, input logic [7:0] data,
                          input logic [3:0] cnt, input string name);
        int w;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        cmd_cnt   = cnt;
        w = 0;
        while (cmd_ready !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (cmd_ready !== 1'b1) begin
            errors++;
            checks++;
            $display("FAIL %s accept: cmd_ready never rose, got %b required 1", name, cmd_ready);
            cmd_valid = 1'b0;
            return;
        end
        @(negedge clk);
        // Scramble inputs to prove the command was latched on accept
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_data  = 8'($urandom);
        cmd_cnt   = 4'($urandom);
        watch_cmd(op, data, cnt, name);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        cmd_valid = 1'b1;
        cmd_op = OP_LOAD;
        cmd_data = 8'hFF;
        cmd_cnt = 4'd0;
        repeat (2) @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset cmd_ready: got %b required 1", cmd_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b required 0", busy); end
        checks++; if (sr_en !== 1'b0) begin errors++; $display("FAIL reset sr_en: got %b required 0", sr_en); end
        checks++; if (sr_d !== 1'b0) begin errors++; $display("FAIL reset sr_d: got %b required 0", sr_d); end
        checks++; if (sr_dir !== 1'b0) begin errors++; $display("FAIL reset sr_dir: got %b required 0", sr_dir); end
        checks++; if (sr_circular !== 1'b0) begin errors++; $display("FAIL reset sr_circular: got %b required 0", sr_circular); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset done: got %b required 0", done); end
        checks++; if (res_data !== 8'h00) begin errors++; $display("FAIL reset res_data: got %h required 00", res_data); end
        rst = 1'b0;
        cmd_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || sr_en !== 1'b0) begin
            errors++;
            $display("FAIL reset no_accept: cmd_ready=%b sr_en=%b, required 1/0", cmd_ready, sr_en);
        end
        $display("reset: cmd_ready=%b busy=%b res=%h", cmd_ready, busy, res_data);
    endtask

    task automatic test_load;
        do_cmd(OP_LOAD, 8'hA5, 4'd0, "load_a5");
        checks++;
        if (res_data !== 8'hA5) begin errors++; $display("FAIL load_a5 const: got %h required a5", res_data); end
    endtask

    task automatic test_rotl;
        do_cmd(OP_ROTL, 8'h00, 4'd3, "rotl3");
        checks++;
        if (res_data !== 8'h2D) begin errors++; $display("FAIL rotl3 const: got %h required 2d", res_data); end
        do_cmd(OP_LOAD, 8'hA5, 4'd9, "reload_a5");
        do_cmd(OP_ROTL, 8'h00, 4'd0, "rotl0");
        checks++;
        if (res_data !== 8'hA5) begin errors++; $display("FAIL rotl0 const: got %h required a5", res_data); end
    endtask

    task automatic test_reduce;
        do_cmd(OP_LOAD, 8'hA5, 4'd0, "load_a5_r");
        do_cmd(OP_ROTR, 8'h00, 4'd11, "rotr11");
        checks++;
        if (res_data !== 8'hB4) begin errors++; $display("FAIL rotr11 const: got %h required b4", res_data); end
        do_cmd(OP_LOAD, 8'hA5, 4'd0, "load_a5_l");
        do_cmd(OP_ROTL, 8'h00, 4'd6, "rotl6");
        checks++;
        if (res_data !== 8'h69) begin errors++; $display("FAIL rotl6 const: got %h required 69", res_data); end
    endtask

    task automatic test_clear;
        do_cmd(OP_CLEAR, 8'hFF, 4'd5, "clear");
    endtask

    task automatic test_abort;
        int seen_en;
        int seen_done;
        do_cmd(OP_ROTR, 8'h00, 4'd1, "pre_abort_rotr");
        cmd_valid = 1'b1;
        cmd_op = OP_LOAD;
        cmd_data = 8'hA5;
        cmd_cnt = 4'd0;
        for (int w = 0; w < 50 && cmd_ready !== 1'b1; w++) @(negedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        seen_en = (sr_en === 1'b1) ? 1 : 0;
        repeat (3) begin
            @(negedge clk);
            if (sr_en === 1'b1) seen_en++;
        end
        checks++;
        if (seen_en != 4) begin errors++; $display("FAIL abort pre_shifts: got %0d required 4", seen_en); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (sr_en !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort state: sr_en=%b cmd_ready=%b done=%b, required 0/1/0", sr_en, cmd_ready, done);
        end
        checks++;
        if (res_data !== 8'h00) begin errors++; $display("FAIL abort res_data: got %h required 00", res_data); end
        seen_done = 0;
        seen_en = 0;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1) seen_done++;
            if (sr_en === 1'b1) seen_en++;
        end
        checks++;
        if (seen_done != 0 || seen_en != 0) begin
            errors++;
            $display("FAIL abort quiet: done pulses %0d sr_en cycles %0d, required 0/0", seen_done, seen_en);
        end
        $display("abort: sr_en=%b cmd_ready=%b res=%h", sr_en, cmd_ready, res_data);
    endtask

    task automatic test_held_valid;
        cmd_valid = 1'b1;
        cmd_op = OP_LOAD;
        cmd_data = 8'hA5;
        cmd_cnt = 4'd0;
        for (int w = 0; w < 50 && cmd_ready !== 1'b1; w++) @(negedge clk);
        @(negedge clk);
        // Second command offered and held for the whole of the first
        cmd_op = OP_ROTL;
        cmd_data = 8'h00;
        cmd_cnt = 4'd3;
        watch_cmd(OP_LOAD, 8'hA5, 4'd0, "held_first");
        @(negedge clk);
        cmd_valid = 1'b0;
        watch_cmd(OP_ROTL, 8'h00, 4'd3, "held_second");
        checks++;
        if (res_data !== 8'h2D) begin errors++; $display("FAIL held_second const: got %h required 2d", res_data); end
    endtask

    task automatic test_random;
        logic [1:0] op;
        logic [7:0] data;
        logic [3:0] cnt;
        for (int i = 0; i < 40; i++) begin
            op   = 2'($urandom_range(0, 3));
            data = 8'($urandom);
            cnt  = 4'($urandom_range(0, 15));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_cmd(op, data, cnt, $sformatf("rand%0d", i));
        end
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = 2'b00;
        cmd_data = 8'h00;
        cmd_cnt = 4'd0;
        test_reset;
        test_load;
        test_rotl;
        test_reduce;
        test_clear;
        test_abort;
        test_held_valid;
        test_random;
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shift_seq_ctrl.md
# shift_seq_ctrl

Command sequencer for the bidirectional shift register (`bidir_shift_reg`). It accepts load, rotate and clear commands over a valid/ready handshake. For each command it drives the register's `d`/`en`/`dir`/`circular` controls cycle by cycle, then captures the register's parallel output into a result word. It is the only driver of the register's control inputs and sits between the register and the host logic.

## Interface
- `WIDTH`, 8: shift register length in bits. Must match the controlled register.
- `CNT_W`, `$clog2(WIDTH)+1`: width of the rotate count. Derived; do not override.

- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  controller idle; command accepted when `cmd_valid && cmd_ready` at a rising edge.
- `cmd_op`  in  2  00 LOAD, 01 ROTL, 10 ROTR, 11 CLEAR.
- `cmd_data`  in  WIDTH  LOAD payload.
- `cmd_cnt`  in  CNT_W  rotate count, 0..2*WIDTH-1. Ignored by LOAD and CLEAR.
- `sr_d`  out  1  serial data to the register.
- `sr_en`  out  1  shift enable to the register.
- `sr_dir`  out  1  0 = left, 1 = right.
- `sr_circular`  out  1  rotate mode.
- `sr_q`  in  WIDTH  register parallel output.
- `busy`  out  1  command in progress (= `!cmd_ready`).
- `done`  out  1  one-cycle pulse; `res_data` updated.
- `res_data`  out  WIDTH  `sr_q` captured after the last shift.

## Operation
- Register contract:
  - with `en=1`: left gives `q <= {q[WIDTH-2:0], d}`; right gives `q <= {d, q[WIDTH-1:1]}`.
  - `circular=1` replaces `d` with the bit shifted out.
  - with `en=0`: hold.
- States are IDLE, RUN and CAP. `cmd_ready=1` only in IDLE.
- On accept, the controller latches op/data/count and computes N:
  - LOAD and CLEAR: N = WIDTH.
  - ROTL and ROTR: N = `cmd_cnt`, or as modified under Configuration.
  - Next state is RUN if N>0, else CAP.
- RUN drives `sr_en=1` for exactly N consecutive cycles, with an internal down-counter.
  - LOAD: dir=0, circular=0. Bit i (i=0..WIDTH-1) drives `sr_d = cmd_data[WIDTH-1-i]` (MSB first), so `sr_q == cmd_data` afterwards.
  - CLEAR: dir=0, circular=0, `sr_d=0`.
  - ROTL: dir=0, circular=1, `sr_d=0`.
  - ROTR: dir=1, circular=1, `sr_d=0`.
- CAP lasts one cycle and lets the final shift settle. At the end of CAP: `res_data <= sr_q`, `done <= 1`, state goes to IDLE.
- Outside RUN: `sr_en=0`, `sr_d=0`. `sr_dir` and `sr_circular` hold their last values.
- `cmd_valid` while busy is ignored, not queued. The host holds it until `cmd_ready`.
- Reset values: state IDLE, `cmd_ready=1`, `busy=0`, `sr_en=0`, `sr_d=0`, `sr_dir=0`, `sr_circular=0`, `done=0`, `res_data=0`.
- Reset mid-command:
  - Abort: `sr_en=0` from the next cycle, no `done` pulse, `res_data` reset to 0.
  - Register contents are left as partially shifted.

## Timing
- All outputs are registered. `cmd_ready` is combinational from state.
- Accept at edge k:
  - `sr_en` high in cycles k..k+N-1, giving shifts at edges k+1..k+N.
  - CAP in cycle k+N.
  - `done`, `res_data` and `cmd_ready` valid in cycle k+N+1.
- N=0: CAP in cycle k, `done` in cycle k+1, no `sr_en`.
- Back-to-back: a command accepted in the `done` cycle starts immediately. The minimum command period is N+2 cycles.

## Configuration
- `SHIFT_SEQ_ROT_REDUCE_EN` defined:
  - Rotates are shortened. First e = `cmd_cnt` >= WIDTH ? `cmd_cnt`-WIDTH : `cmd_cnt`.
  - If e > WIDTH/2, the direction is inverted and N = WIDTH-e; else N = e.
  - The final `res_data` is identical; only cycle count and `sr_dir` differ.
- Undefined: N = `cmd_cnt` exactly, in the commanded direction.

## Test plan
(WIDTH=8)
- Reset 2 cycles → `cmd_ready=1`, all other outputs 0. `cmd_valid` asserted during reset is not accepted.
- LOAD 8'hA5 → `sr_en` high 8 cycles with `sr_d` 1,0,1,0,0,1,0,1. `done` 9 cycles after accept, `res_data=8'hA5`.
- After LOAD A5: ROTL cnt 3 → 3 cycles dir=0 circular=1, `res_data=8'h2D`. ROTL cnt 0 → no `sr_en`, `done` 1 cycle after accept, `res_data=8'hA5`.
- Fresh register loaded with A5, then ROTR cnt 11:
  - Macro off: 11 shift cycles.
  - Macro on: 3 cycles dir=1.
  - Both give `res_data=8'hB4`.
- Fresh register loaded with A5, then ROTL cnt 6:
  - Macro on: 2 cycles with `sr_dir=1`.
  - Macro off: 6 cycles dir=0.
  - Both give `res_data=8'h69`.
- Reset mid-command and held valid:
  - Assert `rst` after 4 LOAD shifts → `sr_en=0` next cycle, no `done`, `cmd_ready=1`.
  - New command held valid during busy → accepted only in the `done` cycle.
